// File: rtl/md5_pkg.sv
// Shared MD5 constants, FSM state encodings and small arithmetic helpers
// used by the streaming MD5 core and its per-step datapath.
package md5_pkg;

  typedef logic [2:0] md5_state_t;

  localparam md5_state_t ST_IDLE     = 3'd0;
  localparam md5_state_t ST_LOAD     = 3'd1;
  localparam md5_state_t ST_COMPRESS = 3'd2;
  localparam md5_state_t ST_FINAL    = 3'd3;
  localparam md5_state_t ST_OUT      = 3'd4;

  localparam logic [127:0] IV = {32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476};

  localparam logic [31:0] K [0:63] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  localparam logic [4:0] S [0:63] = '{
    5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21
  };

  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
    rotl32 = (x << n) | (x >> (6'd32 - {1'b0, n}));
  endfunction

  // Message word index per step; 4-bit arithmetic gives the mod-16 wrap for free.
  function automatic logic [3:0] msg_idx(input logic [5:0] i);
    logic [3:0] li;
    li = i[3:0];
    case (i[5:4])
      2'd0:    msg_idx = li;
      2'd1:    msg_idx = li * 4'd5 + 4'd1;
      2'd2:    msg_idx = li * 4'd3 + 4'd5;
      2'd3:    msg_idx = li * 4'd7;
      default: msg_idx = li;
    endcase
  endfunction

  function automatic logic [127:0] add_abcd(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] sum;
    sum = 128'd0;
    for (int i = 0; i < 4; i++) begin
      sum[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    end
    add_abcd = sum;
  endfunction

endpackage

// File: rtl/md5_step.sv
// One combinational MD5 step: round function, K/S lookup, message word
// selection and the A/B/C/D rotation.
module md5_step
  import md5_pkg::*;
(
  input  logic [5:0]   i_idx,
  input  logic [511:0] i_msg,
  input  logic [127:0] i_abcd,
  output logic [127:0] o_abcd
);

  logic [31:0] w_a, w_b, w_c, w_d, w_f, w_m, w_sum;
  logic [3:0]  w_g;

  assign {w_a, w_b, w_c, w_d} = i_abcd;

  // Round function selected by the step's round number.
  always_comb begin
    w_f = 32'd0;
    case (i_idx[5:4])
      2'd0:    w_f = (w_b & w_c) | (~w_b & w_d);
      2'd1:    w_f = (w_d & w_b) | (~w_d & w_c);
      2'd2:    w_f = w_b ^ w_c ^ w_d;
      2'd3:    w_f = w_c ^ (w_b | ~w_d);
      default: w_f = 32'd0;
    endcase
  end

  // M[0] sits in the top word of the block, so word g starts at 32*(15-g).
  assign w_g    = msg_idx(i_idx);
  assign w_m    = i_msg[{~w_g, 5'd0} +: 32];
  assign w_sum  = w_a + w_f + K[i_idx] + w_m;
  assign o_abcd = {w_d, w_b + rotl32(w_sum, S[i_idx]), w_b, w_c};

endmodule

// File: rtl/md5_stream.sv
// Streaming MD5 core: collects pre-padded 512-bit blocks beat by beat,
// compresses UNROLL steps per clock and presents {A,B,C,D} on the final block.
module md5_stream
  import md5_pkg::*;
#(
  parameter int IN_W   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            abort_i,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_first,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    digest_o,
  output logic            busy_o
);

  localparam int         BEATS     = 512 / IN_W;
  localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);
  localparam logic [5:0] STEP_INC  = 6'(UNROLL);
  localparam logic [5:0] LAST_STEP = 6'(64 - UNROLL);

  md5_state_t     r_state;
  logic [3:0]     r_beat;
  logic [5:0]     r_step;
  logic [511:0]   r_msg;
  logic [127:0]   r_h;
  logic [127:0]   r_work;
  logic           r_last;
  logic           r_out_valid;
  logic [127:0]   r_digest;
  logic [8:0]     w_off;
  logic [127:0]   w_chain [0:UNROLL];
  logic [127:0]   w_sum;

  assign w_chain[0] = r_work;

  for (genvar gi = 0; gi < UNROLL; gi++) begin : g_step
    md5_step u_step (
      .i_idx  (r_step + 6'(gi)),
      .i_msg  (r_msg),
      .i_abcd (w_chain[gi]),
      .o_abcd (w_chain[gi+1])
    );
  end

  // Beat k lands at the top of the block first, so offset = (BEATS-1-k)*IN_W.
  assign w_off     = 9'((LAST_BEAT - r_beat) * IN_W);
  assign w_sum     = add_abcd(r_h, r_work);
  assign in_ready  = (r_state == ST_IDLE) || (r_state == ST_LOAD);
  assign busy_o    = (r_state != ST_IDLE);
  assign out_valid = r_out_valid;
  assign digest_o  = r_digest;

  // Block FSM; abort behaves like a synchronous flush that beats every handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_beat      <= 4'd0;
      r_step      <= 6'd0;
      r_msg       <= 512'd0;
      r_h         <= IV;
      r_work      <= IV;
      r_last      <= 1'b0;
      r_out_valid <= 1'b0;
      r_digest    <= 128'd0;
    end else if (abort_i) begin
      r_state     <= ST_IDLE;
      r_beat      <= 4'd0;
      r_step      <= 6'd0;
      r_h         <= IV;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_LOAD: begin
          if (in_valid) begin
            r_msg[w_off +: IN_W] <= in_data;
            if ((r_beat == 4'd0) && in_first) begin
              r_h <= IV;
            end
            if (r_beat == LAST_BEAT) begin
              r_beat  <= 4'd0;
              r_step  <= 6'd0;
              r_last  <= in_last;
              r_work  <= r_h;
              r_state <= ST_COMPRESS;
            end else begin
              r_beat  <= r_beat + 4'd1;
              r_state <= ST_LOAD;
            end
          end
        end
        ST_COMPRESS: begin
          r_work <= w_chain[UNROLL];
          r_step <= r_step + STEP_INC;
          if (r_step == LAST_STEP) begin
            r_state <= ST_FINAL;
          end
        end
        ST_FINAL: begin
          r_h <= w_sum;
          if (r_last) begin
            r_digest    <= w_sum;
            r_out_valid <= 1'b1;
            r_state     <= ST_OUT;
          end else begin
            r_state <= ST_LOAD;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_stream.sv
// Directed bench for md5_stream: known MD5 vectors across three beat-width /
// unroll configurations, latency, backpressure, abort and mid-block reset.
module tb_md5_stream;

  logic clk, reset, abort_i, out_ready, in_first, in_last;
  logic v32, v64, v128, r32, r64, r128, ov32, ov64, ov128, b32, b64, b128;
  logic [31:0]  d32;
  logic [63:0]  d64;
  logic [127:0] d128;
  logic [127:0] g32, g64, g128;
  logic         s_rdy, s_ov, s_busy;
  logic [127:0] s_dig;
  int           cur, n_checks, n_fail;

  localparam logic [127:0] DIG_ABC    = 128'h98500190_b04fd23c_7d3f96d6_727fe128;
  localparam logic [127:0] DIG_EMPTY  = 128'hd98c1dd4_04b2008f_980980e9_7e42f8ec;
  localparam logic [127:0] DIG_DIGITS = 128'ha2f4ed57_55c9e32b_2eda49ac_7ab60721;

  logic [511:0]  blk_abc, blk_empty;
  logic [1023:0] blk_digits;

  md5_stream #(.IN_W(32), .UNROLL(1)) dut32 (
    .clk(clk), .reset(reset), .abort_i(abort_i), .in_valid(v32), .in_ready(r32),
    .in_data(d32), .in_first(in_first), .in_last(in_last), .out_valid(ov32),
    .out_ready(out_ready), .digest_o(g32), .busy_o(b32));
  md5_stream #(.IN_W(64), .UNROLL(2)) dut64 (
    .clk(clk), .reset(reset), .abort_i(abort_i), .in_valid(v64), .in_ready(r64),
    .in_data(d64), .in_first(in_first), .in_last(in_last), .out_valid(ov64),
    .out_ready(out_ready), .digest_o(g64), .busy_o(b64));
  md5_stream #(.IN_W(128), .UNROLL(4)) dut128 (
    .clk(clk), .reset(reset), .abort_i(abort_i), .in_valid(v128), .in_ready(r128),
    .in_data(d128), .in_first(in_first), .in_last(in_last), .out_valid(ov128),
    .out_ready(out_ready), .digest_o(g128), .busy_o(b128));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign s_rdy  = (cur == 0) ? r32  : (cur == 1) ? r64  : r128;
  assign s_ov   = (cur == 0) ? ov32 : (cur == 1) ? ov64 : ov128;
  assign s_busy = (cur == 0) ? b32  : (cur == 1) ? b64  : b128;
  assign s_dig  = (cur == 0) ? g32  : (cur == 1) ? g64  : g128;

  // RFC 1321 vector "1234567890" x8 (80 bytes), padded to two blocks.
  function automatic logic [1023:0] mk_digits();
    logic [7:0]    b [0:127];
    logic [1023:0] r;
    for (int i = 0; i < 128; i++) b[i] = 8'h00;
    for (int i = 0; i < 80; i++) b[i] = 8'h30 + 8'((i + 1) % 10);
    b[80]  = 8'h80;
    b[120] = 8'h80;
    b[121] = 8'h02;
    r = 1024'd0;
    for (int j = 0; j < 32; j++) r[1023 - 32*j -: 32] = {b[4*j+3], b[4*j+2], b[4*j+1], b[4*j]};
    return r;
  endfunction

  task automatic drive_block(input logic [511:0] blk, input logic first, input logic last, input bit gaps);
    int nb, w, wc;
    logic [511:0] sh;
    nb = (cur == 0) ? 16 : (cur == 1) ? 8 : 4;
    w  = 512 / nb;
    for (int k = 0; k < nb; k++) begin
      if (gaps) begin
        v32 = 1'b0; v64 = 1'b0; v128 = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      sh = blk << (k * w);
      d32 = sh[511:480]; d64 = sh[511:448]; d128 = sh[511:384];
      in_first = (k == 0) ? first : ~first;
      in_last  = (k == nb - 1) ? last : ~last;
      v32 = (cur == 0); v64 = (cur == 1); v128 = (cur == 2);
      wc = 0;
      while (!s_rdy && wc < 200) begin
        @(negedge clk);
        wc++;
      end
      if (wc >= 200) begin
        n_checks++; n_fail++;
        $display("FAIL beat_accept: in_ready low for %0d cycles, required 1", wc);
      end
      @(posedge clk);
      @(negedge clk);
    end
    v32 = 1'b0; v64 = 1'b0; v128 = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!s_ov && lat < 300) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (ov32 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", ov32); end
    n_checks++; if (g32 !== 128'd0) begin n_fail++; $display("FAIL reset_digest: got %h, required 0", g32); end
    n_checks++; if (b32 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", b32); end
    n_checks++; if (r32 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", r32); end
    n_checks++; if ({ov64, ov128, b64, b128} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_wide: got %b, required 0000", {ov64, ov128, b64, b128});
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_abc();
    int lat;
    cur = 0;
    drive_block(blk_abc, 1'b1, 1'b1, 1'b0);
    wait_out(lat);
    n_checks++; if (lat !== 65) begin n_fail++; $display("FAIL abc_latency: got %0d, required 65", lat); end
    n_checks++; if (s_dig !== DIG_ABC) begin n_fail++; $display("FAIL abc_digest: got %h, required %h", s_dig, DIG_ABC); end
    consume();
    n_checks++; if (s_ov !== 1'b0) begin n_fail++; $display("FAIL abc_drop: got %b, required 0", s_ov); end
    n_checks++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL abc_idle: got %b, required 0", s_busy); end
  endtask

  task automatic test_empty_configs();
    int lat, exp_lat;
    for (int c = 0; c < 3; c++) begin
      cur = c;
      exp_lat = (c == 0) ? 65 : (c == 1) ? 33 : 17;
      drive_block(blk_empty, 1'b1, 1'b1, 1'b0);
      wait_out(lat);
      n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL empty_latency cfg%0d: got %0d, required %0d", c, lat, exp_lat); end
      n_checks++; if (s_dig !== DIG_EMPTY) begin n_fail++; $display("FAIL empty_digest cfg%0d: got %h, required %h", c, s_dig, DIG_EMPTY); end
      consume();
      n_checks++; if (s_ov !== 1'b0) begin n_fail++; $display("FAIL empty_drop cfg%0d: got %b, required 0", c, s_ov); end
    end
    cur = 0;
  endtask

  task automatic test_two_block();
    int lat;
    bit saw;
    cur = 0;
    saw = 1'b0;
    drive_block(blk_digits[1023:512], 1'b1, 1'b0, 1'b0);
    repeat (65) begin
      @(posedge clk);
      @(negedge clk);
      if (s_ov) saw = 1'b1;
    end
    n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL two_block_early_out: got %b, required 0", saw); end
    n_checks++; if (s_rdy !== 1'b1) begin n_fail++; $display("FAIL two_block_load_ready: got %b, required 1", s_rdy); end
    n_checks++; if (s_busy !== 1'b1) begin n_fail++; $display("FAIL two_block_load_busy: got %b, required 1", s_busy); end
    drive_block(blk_digits[511:0], 1'b0, 1'b1, 1'b1);
    wait_out(lat);
    n_checks++; if (lat !== 65) begin n_fail++; $display("FAIL two_block_latency: got %0d, required 65", lat); end
    n_checks++; if (s_dig !== DIG_DIGITS) begin n_fail++; $display("FAIL two_block_digest: got %h, required %h", s_dig, DIG_DIGITS); end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    cur = 0;
    drive_block(blk_abc, 1'b1, 1'b1, 1'b0);
    wait_out(lat);
    for (int t = 0; t < 20; t++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (s_ov !== 1'b1) begin n_fail++; $display("FAIL hold_valid t%0d: got %b, required 1", t, s_ov); end
      n_checks++; if (s_dig !== DIG_ABC) begin n_fail++; $display("FAIL hold_digest t%0d: got %h, required %h", t, s_dig, DIG_ABC); end
      n_checks++; if (s_rdy !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready t%0d: got %b, required 0", t, s_rdy); end
    end
    out_ready = 1'b1;
    n_checks++; if (s_rdy !== 1'b0) begin n_fail++; $display("FAIL handshake_in_ready: got %b, required 0", s_rdy); end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if (s_ov !== 1'b0) begin n_fail++; $display("FAIL handshake_drop: got %b, required 0", s_ov); end
    n_checks++; if (s_rdy !== 1'b1) begin n_fail++; $display("FAIL handshake_idle_ready: got %b, required 1", s_rdy); end
  endtask

  task automatic test_abort();
    int lat;
    bit saw;
    cur = 0;
    saw = 1'b0;
    drive_block(blk_abc, 1'b1, 1'b1, 1'b0);
    repeat (30) begin
      @(posedge clk);
      @(negedge clk);
    end
    abort_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort_i = 1'b0;
    n_checks++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b, required 0", s_busy); end
    n_checks++; if (s_rdy !== 1'b1) begin n_fail++; $display("FAIL abort_in_ready: got %b, required 1", s_rdy); end
    repeat (80) begin
      @(posedge clk);
      @(negedge clk);
      if (s_ov) saw = 1'b1;
    end
    n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL abort_no_out: got %b, required 0", saw); end
    drive_block(blk_abc, 1'b0, 1'b1, 1'b0);
    wait_out(lat);
    n_checks++; if (lat !== 65) begin n_fail++; $display("FAIL abort_after_latency: got %0d, required 65", lat); end
    n_checks++; if (s_dig !== DIG_ABC) begin n_fail++; $display("FAIL abort_after_digest: got %h, required %h", s_dig, DIG_ABC); end
    consume();
  endtask

  task automatic test_reset_midload();
    int lat;
    bit saw;
    cur = 0;
    saw = 1'b0;
    in_first = 1'b1;
    in_last  = 1'b1;
    v32 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      d32 = $urandom;
      @(posedge clk);
      @(negedge clk);
    end
    v32 = 1'b0;
    reset = 1'b0;
    #1;
    n_checks++; if (ov32 !== 1'b0) begin n_fail++; $display("FAIL midload_out_valid: got %b, required 0", ov32); end
    n_checks++; if (g32 !== 128'd0) begin n_fail++; $display("FAIL midload_digest: got %h, required 0", g32); end
    n_checks++; if (b32 !== 1'b0) begin n_fail++; $display("FAIL midload_busy: got %b, required 0", b32); end
    n_checks++; if (r32 !== 1'b1) begin n_fail++; $display("FAIL midload_in_ready: got %b, required 1", r32); end
    @(negedge clk);
    reset = 1'b1;
    repeat (80) begin
      @(posedge clk);
      @(negedge clk);
      if (s_ov || s_busy) saw = 1'b1;
    end
    n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL midload_no_resume: got %b, required 0", saw); end
    drive_block(blk_abc, 1'b0, 1'b1, 1'b1);
    wait_out(lat);
    n_checks++; if (lat !== 65) begin n_fail++; $display("FAIL midload_after_latency: got %0d, required 65", lat); end
    n_checks++; if (s_dig !== DIG_ABC) begin n_fail++; $display("FAIL midload_after_digest: got %h, required %h", s_dig, DIG_ABC); end
    consume();
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cur = 0;
    reset = 1'b0; abort_i = 1'b0; out_ready = 1'b0;
    in_first = 1'b0; in_last = 1'b0;
    v32 = 1'b0; v64 = 1'b0; v128 = 1'b0;
    d32 = 32'd0; d64 = 64'd0; d128 = 128'd0;
    blk_abc    = {32'h80636261, 416'd0, 32'h00000018, 32'h00000000};
    blk_empty  = {32'h00000080, 480'd0};
    blk_digits = mk_digits();
    test_reset();
    test_abc();
    test_empty_configs();
    test_two_block();
    test_backpressure();
    test_abort();
    test_reset_midload();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
